laneid_pattern_checker: RTL and testbench

LANEID_PATTERN_CHECKER -- requirements
Module: laneid_pattern_checker

---
 rtl/laneid_pattern_checker_if.sv | 34 +++
 rtl/laneid_pattern_checker.sv | 156 +++++++++++++++
 tb/tb_laneid_pattern_checker.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/laneid_pattern_checker_if.sv
// Handshake and result bundle for the MBINIT REVERSALMB Lane-ID pattern checker.
// The master side drives run control and receive data; the slave side is the checker.
interface laneid_pattern_checker_if;
    logic        i_enable;
    logic [1:0]  i_Clear_Pattern_Comparator;
    logic        i_rx_valid;
    logic [15:0] i_rx_data;
    logic        o_LaneID_Pattern_done;
    logic [15:0] o_REVERSAL_Result_logged;
    logic        o_result_valid;
    logic        o_busy;

    modport master (
        output i_enable,
        output i_Clear_Pattern_Comparator,
        output i_rx_valid,
        output i_rx_data,
        input  o_LaneID_Pattern_done,
        input  o_REVERSAL_Result_logged,
        input  o_result_valid,
        input  o_busy
    );

    modport slave (
        input  i_enable,
        input  i_Clear_Pattern_Comparator,
        input  i_rx_valid,
        input  i_rx_data,
        output o_LaneID_Pattern_done,
        output o_REVERSAL_Result_logged,
        output o_result_valid,
        output o_busy
    );
endinterface

// File: rtl/laneid_pattern_checker.sv
// Compares the 16-bit Lane-ID frame received on each of 16 mainband lanes against
// {1010, lane_id, 1010} for ITERATIONS frames and logs a per-lane pass/fail result.
module laneid_pattern_checker #(
    parameter int unsigned ITERATIONS    = 128,
    parameter int unsigned ERR_THRESHOLD = 16
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    laneid_pattern_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_LANES     = 16;
    localparam logic [7:0]  LP_LAST_FRAME = 8'(ITERATIONS - 1);
    localparam logic [7:0]  LP_THRESHOLD  = 8'(ERR_THRESHOLD);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_frame_cnt;
    logic [15:0] r_frame_err;
    logic [7:0]  r_err_cnt [NUM_LANES];
    logic        r_done;
    logic [15:0] r_result;
    logic        r_result_valid;
    logic        r_busy;

    logic        w_clear;
    logic        w_accept;
    logic        w_frame_end;
    logic        w_run_end;
    logic [15:0] w_exp_bits;
    logic [15:0] w_lane_bad;
    logic [7:0]  w_err_next [NUM_LANES];
    logic [15:0] w_pass;

    assign w_clear     = |bus.i_Clear_Pattern_Comparator;
    // A bit is only consumed while running, enabled and not being cleared.
    assign w_accept    = (r_state == ST_RUN) && bus.i_enable && !w_clear && bus.i_rx_valid;
    assign w_frame_end = w_accept && (r_bit_cnt == 4'd15);
    assign w_run_end   = w_frame_end && (r_frame_cnt == LP_LAST_FRAME);

    // Frames arrive MSB first, so bit_cnt selects pattern bit (15 - bit_cnt).
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        localparam logic [15:0] LP_PATTERN = {4'b1010, 8'(gi), 4'b1010};
        assign w_exp_bits[gi] = LP_PATTERN[4'd15 - r_bit_cnt];
    end

    // The final-bit compare must count toward the frame being closed this cycle.
    assign w_lane_bad = r_frame_err | (w_exp_bits ^ bus.i_rx_data);

    always_comb begin
        // NOTE: every combinational output is given a value before any branch, so no latch is inferred.
        w_pass = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_err_next[i] = r_err_cnt[i];
            if (w_lane_bad[i] && (r_err_cnt[i] != 8'hFF)) begin
                w_err_next[i] = r_err_cnt[i] + 8'd1;
            end
            w_pass[i] = (w_err_next[i] <= LP_THRESHOLD);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clear) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.i_enable) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!bus.i_enable) begin
                        w_state_next = ST_IDLE;
                    end else if (w_run_end) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_DONE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt      <= '0;
            r_frame_cnt    <= '0;
            r_frame_err    <= '0;
            r_done         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            // NOTE: the error counters are reset too; they are plain flops and a run must start from zero.
            for (int i = 0; i < NUM_LANES; i++) begin
                r_err_cnt[i] <= '0;
            end
        end else begin
            r_busy <= (w_state_next == ST_RUN);
            r_done <= 1'b0;
            if (w_state_next == ST_IDLE) begin
                r_bit_cnt      <= '0;
                r_frame_cnt    <= '0;
                r_frame_err    <= '0;
                r_result       <= '0;
                r_result_valid <= 1'b0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    r_err_cnt[i] <= '0;
                end
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                if (w_frame_end) begin
                    r_frame_err <= '0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        r_err_cnt[i] <= w_err_next[i];
                    end
                end else begin
                    r_frame_err <= w_lane_bad;
                end
                if (w_run_end) begin
                    r_done         <= 1'b1;
                    r_result       <= w_pass;
                    r_result_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.o_LaneID_Pattern_done    = r_done;
    assign bus.o_REVERSAL_Result_logged = r_result;
    assign bus.o_result_valid           = r_result_valid;
    assign bus.o_busy                   = r_busy;

endmodule

// File: tb/tb_laneid_pattern_checker.sv
// Drives two checker instances (4 frames/threshold 16 and 8 frames/threshold 2) with shared
// stimulus and compares every cycle against a bit-count based reference model.
module tb_laneid_pattern_checker;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  clr = 2'b00;
    logic        v = 1'b0;
    logic [15:0] data = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    laneid_pattern_checker_if bus_a ();
    laneid_pattern_checker_if bus_b ();

    assign bus_a.i_enable                   = en;
    assign bus_a.i_Clear_Pattern_Comparator = clr;
    assign bus_a.i_rx_valid                 = v;
    assign bus_a.i_rx_data                  = data;
    assign bus_b.i_enable                   = en;
    assign bus_b.i_Clear_Pattern_Comparator = clr;
    assign bus_b.i_rx_valid                 = v;
    assign bus_b.i_rx_data                  = data;

    laneid_pattern_checker #(.ITERATIONS(4), .ERR_THRESHOLD(16)) dut_a (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    laneid_pattern_checker #(.ITERATIONS(8), .ERR_THRESHOLD(2)) dut_b (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Reference model: 0 = idle, 1 = run, 2 = done; progress is the count of accepted bits.
    int          iters [2] = '{4, 8};
    int          thr   [2] = '{16, 2};
    int          m_phase [2];
    int          m_bits  [2];
    int          m_errs  [2][16];
    logic [15:0] m_bad   [2];
    logic [15:0] m_res   [2];
    logic        m_valid [2];
    logic        m_done  [2];

    function automatic logic [15:0] lane_frame(input int lane);
        return {4'b1010, 8'(lane), 4'b1010};
    endfunction

    function automatic logic [15:0] good_word(input int pos);
        logic [15:0] w;
        logic [15:0] f;
        w = '0;
        for (int lane = 0; lane < 16; lane++) begin
            f = lane_frame(lane);
            w[lane] = f[15 - pos];
        end
        return w;
    endfunction

    task automatic model_clear(input int k);
        m_phase[k] = 0;
        m_bits[k]  = 0;
        m_bad[k]   = '0;
        m_res[k]   = '0;
        m_valid[k] = 1'b0;
        for (int lane = 0; lane < 16; lane++) m_errs[k][lane] = 0;
    endtask

    task automatic model_step();
        int pos;
        logic [15:0] f;
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (clr != 2'b00) begin
                model_clear(k);
            end else if (m_phase[k] == 0) begin
                if (en) begin
                    model_clear(k);
                    m_phase[k] = 1;
                end
            end else if (m_phase[k] == 1) begin
                if (!en) begin
                    model_clear(k);
                end else if (v) begin
                    pos = m_bits[k] % 16;
                    for (int lane = 0; lane < 16; lane++) begin
                        f = lane_frame(lane);
                        if (data[lane] != f[15 - pos]) m_bad[k][lane] = 1'b1;
                    end
                    m_bits[k]++;
                    if (m_bits[k] % 16 == 0) begin
                        for (int lane = 0; lane < 16; lane++)
                            if (m_bad[k][lane] && m_errs[k][lane] < 255) m_errs[k][lane]++;
                        m_bad[k] = '0;
                        if (m_bits[k] / 16 == iters[k]) begin
                            m_phase[k] = 2;
                            m_done[k]  = 1'b1;
                            m_valid[k] = 1'b1;
                            for (int lane = 0; lane < 16; lane++)
                                m_res[k][lane] = (m_errs[k][lane] <= thr[k]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_done",   32'(bus_a.o_LaneID_Pattern_done),    32'(m_done[0]));
        check("a_result", 32'(bus_a.o_REVERSAL_Result_logged), 32'(m_res[0]));
        check("a_valid",  32'(bus_a.o_result_valid),           32'(m_valid[0]));
        check("a_busy",   32'(bus_a.o_busy),                   32'(m_phase[0] == 1));
        check("b_done",   32'(bus_b.o_LaneID_Pattern_done),    32'(m_done[1]));
        check("b_result", 32'(bus_b.o_REVERSAL_Result_logged), 32'(m_res[1]));
        check("b_valid",  32'(bus_b.o_result_valid),           32'(m_valid[1]));
        check("b_busy",   32'(bus_b.o_busy),                   32'(m_phase[1] == 1));
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic start_run();
        en = 1'b0; clr = 2'b01; v = 1'b0;
        step();
        en = 1'b1; clr = 2'b00;
        step();
        check("start_busy_a", 32'(bus_a.o_busy), 32'd1);
    endtask

    task automatic send_good(input int first, input int count);
        for (int n = first; n < first + count; n++) begin
            v = 1'b1;
            data = good_word(n % 16);
            step();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_a_done"},   32'(bus_a.o_LaneID_Pattern_done),    32'd0);
        check({tag, "_a_result"}, 32'(bus_a.o_REVERSAL_Result_logged), 32'd0);
        check({tag, "_a_valid"},  32'(bus_a.o_result_valid),           32'd0);
        check({tag, "_a_busy"},   32'(bus_a.o_busy),                   32'd0);
        check({tag, "_b_done"},   32'(bus_b.o_LaneID_Pattern_done),    32'd0);
        check({tag, "_b_result"}, 32'(bus_b.o_REVERSAL_Result_logged), 32'd0);
        check({tag, "_b_valid"},  32'(bus_b.o_result_valid),           32'd0);
        check({tag, "_b_busy"},   32'(bus_b.o_busy),                   32'd0);
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  clr;
        logic        v;
        logic [15:0] data;
        logic        busy;
        logic        done;
        logic        valid;
        logic [15:0] result;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          pos;
        logic [15:0] w;

        vecs[0] = '{1'b0, 2'b00, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 2'b01, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 2'b00, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{1'b0, 2'b00, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{1'b1, 2'b11, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{1'b1, 2'b00, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[7] = '{1'b1, 2'b10, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000};

        // Reset state, held with enable high to show nothing moves while rst_n is low.
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            m_done[k] = 1'b0;
        end
        en = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_outputs_zero("reset");
        en = 1'b0;
        rst_n = 1'b1;

        // Table-driven control vectors from IDLE.
        for (int i = 0; i < 8; i++) begin
            en = vecs[i].en; clr = vecs[i].clr; v = vecs[i].v; data = vecs[i].data;
            step();
            check($sformatf("vec%0d_busy", i),   32'(bus_a.o_busy),                   32'(vecs[i].busy));
            check($sformatf("vec%0d_done", i),   32'(bus_b.o_LaneID_Pattern_done),    32'(vecs[i].done));
            check($sformatf("vec%0d_valid", i),  32'(bus_a.o_result_valid),           32'(vecs[i].valid));
            check($sformatf("vec%0d_result", i), 32'(bus_b.o_REVERSAL_Result_logged), 32'(vecs[i].result));
        end

        // Clean pass: A finishes after 64 valid bits, B after 128; enable held high afterwards.
        start_run();
        send_good(0, 63);
        check("clean_a_no_early_done", 32'(bus_a.o_LaneID_Pattern_done), 32'd0);
        send_good(63, 1);
        check("clean_a_done",   32'(bus_a.o_LaneID_Pattern_done),    32'd1);
        check("clean_a_result", 32'(bus_a.o_REVERSAL_Result_logged), 32'hFFFF);
        check("clean_a_valid",  32'(bus_a.o_result_valid),           32'd1);
        send_good(64, 1);
        check("clean_a_done_pulse", 32'(bus_a.o_LaneID_Pattern_done), 32'd0);
        check("clean_a_hold",       32'(bus_a.o_REVERSAL_Result_logged), 32'hFFFF);
        send_good(65, 63);
        check("clean_b_done",   32'(bus_b.o_LaneID_Pattern_done),    32'd1);
        check("clean_b_result", 32'(bus_b.o_REVERSAL_Result_logged), 32'hFFFF);
        v = 1'b0;
        repeat (3) step();
        check("no_restart_a_busy", 32'(bus_a.o_busy), 32'd0);
        check("no_restart_b_busy", 32'(bus_b.o_busy), 32'd0);
        en = 1'b0; v = 1'b1; data = $urandom();
        step();
        check("done_hold_b_valid",  32'(bus_b.o_result_valid),           32'd1);
        check("done_hold_b_result", 32'(bus_b.o_REVERSAL_Result_logged), 32'hFFFF);

        // Threshold edge on B: lane 3 bad in 2 frames, lane 5 bad in 3 (last one on bit 15).
        start_run();
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 16; b++) begin
                w = good_word(b);
                if ((f == 1 || f == 4) && (b == 6 || b == 7)) w[3] = ~w[3];
                if ((f == 0 || f == 2) && b == 9) w[5] = ~w[5];
                if (f == 7 && b == 15) w[5] = ~w[5];
                v = 1'b1; data = w;
                step();
            end
        end
        check("thresh_b_done",   32'(bus_b.o_LaneID_Pattern_done),    32'd1);
        check("thresh_b_result", 32'(bus_b.o_REVERSAL_Result_logged), 32'hFFDF);

        // Valid gaps: alternating valid, garbage data on idle cycles.
        start_run();
        for (int n = 0; n < 64; n++) begin
            v = 1'b1; data = good_word(n % 16);
            step();
            if (n == 63) begin
                check("gap_a_done",   32'(bus_a.o_LaneID_Pattern_done),    32'd1);
                check("gap_a_result", 32'(bus_a.o_REVERSAL_Result_logged), 32'hFFFF);
            end
            v = 1'b0; data = 16'($urandom());
            step();
        end

        // Abort after 20 bits, then re-enable for a full clean pass.
        start_run();
        send_good(0, 20);
        en = 1'b0; v = 1'b1; data = good_word(4);
        step();
        check_outputs_zero("abort");
        en = 1'b1; v = 1'b0;
        step();
        send_good(0, 64);
        check("reenable_a_done",   32'(bus_a.o_LaneID_Pattern_done),    32'd1);
        check("reenable_a_result", 32'(bus_a.o_REVERSAL_Result_logged), 32'hFFFF);

        // Clear on the final bit of the last frame wins over completion.
        start_run();
        send_good(0, 63);
        clr = 2'b01; v = 1'b1; data = good_word(15);
        step();
        check("clrfinal_a_done",   32'(bus_a.o_LaneID_Pattern_done),    32'd0);
        check("clrfinal_a_busy",   32'(bus_a.o_busy),                   32'd0);
        check("clrfinal_a_result", 32'(bus_a.o_REVERSAL_Result_logged), 32'd0);
        start_run();
        send_good(0, 64);
        check("clrdone_pre_valid", 32'(bus_a.o_result_valid), 32'd1);
        clr = 2'b10; v = 1'b0;
        step();
        check("clrdone_a_valid",  32'(bus_a.o_result_valid),           32'd0);
        check("clrdone_a_result", 32'(bus_a.o_REVERSAL_Result_logged), 32'd0);

        // Asynchronous reset in the third frame.
        start_run();
        send_good(0, 40);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            m_done[k] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #1;
        check_outputs_zero("rst_held");
        en = 1'b0; v = 1'b1;
        rst_n = 1'b1;
        step();
        check("rst_idle_busy", 32'(bus_a.o_busy), 32'd0);
        en = 1'b1;
        step();
        check("rst_restart_busy", 32'(bus_b.o_busy), 32'd1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 6000; c++) begin
            en  = ($urandom_range(0, 499) != 0);
            clr = ($urandom_range(0, 399) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v   = ($urandom_range(0, 3) != 0);
            pos = (m_phase[1] == 1) ? (m_bits[1] % 16) : (m_bits[0] % 16);
            w   = good_word(pos);
            if ($urandom_range(0, 7) == 0) w = w ^ (16'h0001 << $urandom_range(0, 15));
            data = w;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
